dacarb: RTL and testbench
=========================

DACARB -- requirements
Module: dacarb

Interface
REQ-001 The block SHALL have exactly one clock, dacclk; reset is asynchronous and active-low (rstn).
REQ-002 Port list SHALL be (name, direction, width, meaning):
- dacclk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  requester N wants one DAC transfer; level-held.
- cmd0, cmd1  in  8 each  requester N command byte.
- data0, data1  in  8 each  requester N data byte.
- ack0, ack1  out  1 each  one-cycle pulse: requester N transfer completed.
- err0, err1  out  1 each  one-cycle pulse: requester N transfer timed out.
- daccmd  out  8  command to serializer.
- dacdata  out  8  data to serializer.
- dacdav  out  1  data valid to serializer.
- davdac  in  1  serializer done/acknowledge.
- gnt  out  1  index of the requester currently or last served.
- busy  out  1  high in any state except IDLE.
- tofault  out  1  sticky timeout flag.

Function
REQ-003 The block SHALL share one DAC serializer between two requesters, with one transfer in flight at a time.
REQ-004 The FSM SHALL have states IDLE, LOAD, WAIT and RELEASE, with one transition per dacclk edge at most.
REQ-005 In IDLE, if either req is high, the block SHALL grant round-robin:
- If both are high, grant the requester not served last.
- If one is high, grant it.
- Latch its cmd/data into daccmd/dacdata, set gnt, go to LOAD.
REQ-006 In LOAD, dacdav SHALL stay 0 for exactly one cycle (setup), then the FSM SHALL go to WAIT with dacdav=1 and the timer cleared to 0.
- Latency: dacdav rises on the 2nd edge after req is sampled in IDLE.
REQ-007 In WAIT, the 8-bit timer SHALL increment each cycle.
- davdac=1: pulse ack[gnt] for one cycle, drive dacdav=0, go to RELEASE.
- Otherwise, when the timer reaches 255: pulse err[gnt] for one cycle, set tofault, drive dacdav=0, go to RELEASE.
- davdac=1 in the same cycle the timer reaches 255: ack wins; no err, tofault unchanged.
REQ-008 In RELEASE, the block SHALL hold dacdav=0 until davdac=0 is sampled, then go to IDLE.
- There is no timeout in RELEASE.
REQ-009 daccmd/dacdata SHALL stay stable from LOAD through RELEASE, and also hold their last value in IDLE.
REQ-010 cmd/data SHALL be sampled only at the grant edge; later changes do not affect the transfer in flight.
REQ-011 A requester that drops req before it is granted SHALL get no transfer.
- The requester SHALL drop req in the cycle after its ack or err pulse, or it is treated as a new request.
REQ-012 In IDLE, the block SHALL ignore davdac.
REQ-013 At most one of ack0, ack1, err0, err1 SHALL be high in any cycle.
REQ-014 The round-robin pointer SHALL advance on both ack and err.
REQ-015 Back-to-back transfers SHALL have a minimum spacing of 4 cycles from one dacdav rise to the next dacdav rise, given immediate davdac response.

Reset
REQ-016 On rstn=0, the block SHALL immediately (asynchronously) drive:
- state=IDLE, dacdav=0, daccmd=0, dacdata=0;
- ack0, ack1, err0, err1 = 0, busy=0, gnt=1 (so req0 wins first), timer=0, tofault=0.
REQ-017 Reset asserted mid-transfer SHALL abort it with no ack or err.
- After release, the block SHALL wait in IDLE; it does not wait for davdac=0.
REQ-018 tofault SHALL be cleared only by reset.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Single: req0=1, cmd0=0x13, data0=0x80, davdac=1 three cycles after dacdav rises -> daccmd=0x13, dacdata=0x80, then dacdav=1, then ack0 pulse, gnt=0, err0=0.
- Contention: req0=req1=1 from reset, immediate davdac -> grant order 0,1,0,1; acks alternate; data follows the granted requester.
- Timeout: req1=1, davdac held 0 -> err1 pulses 255 cycles after dacdav rises; tofault=1; dacdav=0; then IDLE; ack1 never pulses.
- Tie: davdac rises in the same cycle the timer reaches 255 -> ack only; tofault stays 0.
- Reset mid-op: rstn low during WAIT -> dacdav=0 asynchronously, no ack or err; after release, req1 pending with req0 low -> req1 served.
- RELEASE hold: davdac held 1 for 10 cycles after ack -> busy stays 1, no new dacdav until davdac=0.

Source files
------------

// File: rtl/dacarb.sv
// ---------------------------------------------------------------------------
// dacarb -- round-robin arbiter sharing one DAC serializer between two
// requesters, with one transfer in flight at a time.
//
// Flow per transfer: IDLE (grant, latch cmd/data) -> LOAD (one setup cycle,
// dacdav low) -> WAIT (dacdav high, 8-bit timer runs) -> RELEASE (dacdav low
// until the serializer drops davdac) -> IDLE.
//
// Ports:
//   dacclk          clock, rising edge
//   rstn            asynchronous active-low reset
//   req0/req1       level-held transfer requests
//   cmd0/cmd1       per-requester command byte (sampled at grant)
//   data0/data1     per-requester data byte (sampled at grant)
//   ack0/ack1       one-cycle pulse: transfer completed for that requester
//   err0/err1       one-cycle pulse: transfer timed out for that requester
//   daccmd/dacdata  command/data presented to the serializer
//   dacdav          data valid to the serializer
//   davdac          serializer done/acknowledge
//   gnt             index of the requester currently or last served
//   busy            high whenever the FSM is not in IDLE
//   tofault         sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module dacarb (
  input  logic       dacclk,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] cmd0,
  input  logic [7:0] cmd1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] daccmd,
  output logic [7:0] dacdata,
  output logic       dacdav,
  input  logic       davdac,
  output logic       gnt,
  output logic       busy,
  output logic       tofault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Last timer value at which a missing davdac still leaves one more cycle;
  // the timer reaches 255 on the edge that flags the timeout.
  localparam logic [7:0] TIMER_LAST = 8'd254;

  state_e     state_q,   state_d;
  logic       gnt_q,     gnt_d;
  logic [7:0] daccmd_q,  daccmd_d;
  logic [7:0] dacdata_q, dacdata_d;
  logic       dacdav_q,  dacdav_d;
  logic [1:0] ack_q,     ack_d;
  logic [1:0] err_q,     err_d;
  logic [7:0] timer_q,   timer_d;
  logic       tofault_q, tofault_d;
  logic       pick;

  // Round-robin choice: on contention serve the requester not served last
  // (gnt_q doubles as the pointer), otherwise whichever one is asking.
  always_comb begin
    pick = gnt_q;
    if (req0 && req1) pick = ~gnt_q;
    else if (req0)    pick = 1'b0;
    else if (req1)    pick = 1'b1;
  end

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    daccmd_d  = daccmd_q;
    dacdata_d = dacdata_q;
    dacdav_d  = dacdav_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    timer_d   = timer_q;
    tofault_d = tofault_q;

    case (state_q)
      IDLE: begin
        // davdac is deliberately ignored here.
        if (req0 || req1) begin
          gnt_d     = pick;
          daccmd_d  = pick ? cmd1  : cmd0;
          dacdata_d = pick ? data1 : data0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        dacdav_d = 1'b1;
        timer_d  = 8'd0;
        state_d  = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // Acknowledge has priority over a timeout landing on the same edge.
        if (davdac) begin
          ack_d[gnt_q] = 1'b1;
          dacdav_d     = 1'b0;
          state_d      = RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          err_d[gnt_q] = 1'b1;
          tofault_d    = 1'b1;
          dacdav_d     = 1'b0;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for the serializer to drop davdac; no timeout here.
        if (!davdac) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge dacclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b1;  // requester 0 wins the first contention
      daccmd_q  <= 8'd0;
      dacdata_q <= 8'd0;
      dacdav_q  <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      timer_q   <= 8'd0;
      tofault_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      daccmd_q  <= daccmd_d;
      dacdata_q <= dacdata_d;
      dacdav_q  <= dacdav_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      tofault_q <= tofault_d;
    end
  end

  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign daccmd  = daccmd_q;
  assign dacdata = dacdata_q;
  assign dacdav  = dacdav_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign tofault = tofault_q;

endmodule

// File: tb/tb_dacarb.sv
// ---------------------------------------------------------------------------
// tb_dacarb -- self-checking bench for dacarb.
//
// A transfer-level model tracks, for the transfer in flight, how many edges
// have passed since it was granted; all outputs are derived from that age,
// the latched command/data and the sticky flags. A compare process checks
// every output against the model on each falling edge. Directed scenarios
// add hand-computed literal expectations, then a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_dacarb;

  logic       dacclk = 1'b0;
  logic       rstn   = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] cmd0 = 8'd0, cmd1 = 8'd0, data0 = 8'd0, data1 = 8'd0;
  logic       davdac = 1'b0;
  logic       ack0, ack1, err0, err1;
  logic [7:0] daccmd, dacdata;
  logic       dacdav, gnt, busy, tofault;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  dacarb dut (
    .dacclk (dacclk),
    .rstn   (rstn),
    .req0   (req0),
    .req1   (req1),
    .cmd0   (cmd0),
    .cmd1   (cmd1),
    .data0  (data0),
    .data1  (data1),
    .ack0   (ack0),
    .ack1   (ack1),
    .err0   (err0),
    .err1   (err1),
    .daccmd (daccmd),
    .dacdata(dacdata),
    .dacdav (dacdav),
    .davdac (davdac),
    .gnt    (gnt),
    .busy   (busy),
    .tofault(tofault)
  );

  always #5 dacclk = ~dacclk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  bit         m_active  = 1'b0;  // a transfer is granted and not yet retired
  bit         m_done    = 1'b0;  // ack/err issued, waiting for davdac low
  int         m_age     = 0;     // edges since the grant edge
  logic       m_last    = 1'b1;  // requester served last
  logic [7:0] m_cmd     = 8'd0;
  logic [7:0] m_data    = 8'd0;
  logic [1:0] m_ack     = 2'b00;
  logic [1:0] m_err     = 2'b00;
  bit         m_tofault = 1'b0;

  always @(posedge dacclk or negedge rstn) begin
    if (!rstn) begin
      m_active = 1'b0; m_done = 1'b0; m_age = 0; m_last = 1'b1;
      m_cmd = 8'd0; m_data = 8'd0; m_ack = 2'b00; m_err = 2'b00;
      m_tofault = 1'b0;
    end else begin
      m_ack = 2'b00;
      m_err = 2'b00;
      if (!m_active) begin
        if (req0 || req1) begin
          m_last   = (req0 && req1) ? ~m_last : (req0 ? 1'b0 : 1'b1);
          m_cmd    = m_last ? cmd1  : cmd0;
          m_data   = m_last ? data1 : data0;
          m_active = 1'b1;
          m_done   = 1'b0;
          m_age    = 0;
        end
      end else if (!m_done) begin
        m_age++;
        // Valid rises at age 1; davdac is judged from age 2 on, and the
        // 255th edge after the rise (age 256) is the timeout edge.
        if (m_age >= 2) begin
          if (davdac) begin
            m_ack[m_last] = 1'b1;
            m_done = 1'b1;
          end else if (m_age - 1 == 255) begin
            m_err[m_last] = 1'b1;
            m_tofault = 1'b1;
            m_done = 1'b1;
          end
        end
      end else if (!davdac) begin
        m_active = 1'b0;
      end
    end
  end

  always @(negedge dacclk) begin
    if (cmp_en) begin
      check("dacdav",  32'(dacdav),  32'(m_active && !m_done && m_age >= 1));
      check("busy",    32'(busy),    32'(m_active));
      check("gnt",     32'(gnt),     32'(m_last));
      check("daccmd",  32'(daccmd),  32'(m_cmd));
      check("dacdata", 32'(dacdata), 32'(m_data));
      check("ack",     32'({ack1, ack0}), 32'(m_ack));
      check("err",     32'({err1, err0}), 32'(m_err));
      check("tofault", 32'(tofault), 32'(m_tofault));
      check("one_pulse", 32'($countones({ack0, ack1, err0, err1}) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge dacclk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; davdac = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic wait_dav(input string name);
    int n = 0;
    while (!dacdav && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(dacdav), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n_ack, cyc, last_rise, rises;
    bit prev_dav, saw_bad;

    tick();
    do_reset();
    cmp_en = 1'b1;
    // Reset state, hand-computed
    check("rst_gnt", 32'(gnt), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_daccmd", 32'(daccmd), 32'd0);
    check("rst_dacdav", 32'(dacdav), 32'd0);
    check("rst_tofault", 32'(tofault), 32'd0);

    // Single transfer from requester 0
    req0 = 1'b1; cmd0 = 8'h13; data0 = 8'h80;
    tick();                                  // grant edge
    cmd0 = 8'hFF; data0 = 8'h00;             // late change must not leak
    check("single_cmd", 32'(daccmd), 32'h13);
    check("single_data", 32'(dacdata), 32'h80);
    check("single_gnt", 32'(gnt), 32'd0);
    check("single_setup_dav", 32'(dacdav), 32'd0);
    tick();
    check("single_dav_rise", 32'(dacdav), 32'd1);
    repeat (2) tick();
    davdac = 1'b1;
    tick();                                  // third edge after the rise
    check("single_ack0", 32'(ack0), 32'd1);
    check("single_err0", 32'(err0), 32'd0);
    check("single_dav_fall", 32'(dacdav), 32'd0);
    check("single_cmd_hold", 32'(daccmd), 32'h13);
    req0 = 1'b0; davdac = 1'b0;
    repeat (2) tick();
    check("single_idle", 32'(busy), 32'd0);

    // Contention with an immediately responding serializer
    do_reset();
    cmd0 = 8'hA0; data0 = 8'hA1; cmd1 = 8'hB0; data1 = 8'hB1;
    req0 = 1'b1; req1 = 1'b1;
    n_ack = 0; cyc = 0; last_rise = 0; rises = 0; prev_dav = 1'b0;
    while (n_ack < 4 && cyc < 100) begin
      davdac = dacdav;
      tick();
      cyc++;
      if (dacdav && !prev_dav) begin
        if (rises > 0) check("rise_spacing", 32'(cyc - last_rise), 32'd4);
        last_rise = cyc;
        rises++;
      end
      prev_dav = dacdav;
      if (ack0 || ack1) begin
        check("cont_order", 32'(ack1), 32'(n_ack % 2));
        check("cont_cmd", 32'(daccmd), (n_ack % 2) ? 32'hB0 : 32'hA0);
        check("cont_data", 32'(dacdata), (n_ack % 2) ? 32'hB1 : 32'hA1);
        n_ack++;
      end
    end
    check("cont_acks", 32'(n_ack), 32'd4);
    req0 = 1'b0; req1 = 1'b0; davdac = 1'b0;
    repeat (4) tick();

    // Timeout on requester 1
    do_reset();
    req1 = 1'b1; cmd1 = 8'h5A; data1 = 8'hC3;
    wait_dav("to_dav_rise");
    n = 0; saw_bad = 1'b0;
    while (!err1 && n < 300) begin
      tick();
      n++;
      if (ack1) saw_bad = 1'b1;
    end
    check("to_latency", 32'(n), 32'd255);
    check("to_err1", 32'(err1), 32'd1);
    check("to_tofault", 32'(tofault), 32'd1);
    check("to_dav_low", 32'(dacdav), 32'd0);
    check("to_no_ack", 32'(saw_bad), 32'd0);
    req1 = 1'b0;
    tick();
    check("to_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check("to_sticky", 32'(tofault), 32'd1);

    // Tie: davdac arrives on the very edge the timer would expire
    do_reset();
    req0 = 1'b1;
    wait_dav("tie_dav_rise");
    repeat (254) tick();
    check("tie_pre_err", 32'(err0), 32'd0);
    davdac = 1'b1;
    tick();
    check("tie_ack0", 32'(ack0), 32'd1);
    check("tie_err0", 32'(err0), 32'd0);
    check("tie_tofault", 32'(tofault), 32'd0);
    req0 = 1'b0; davdac = 1'b0;
    repeat (3) tick();

    // Reset mid-transfer
    do_reset();
    req0 = 1'b1; cmd0 = 8'h77;
    wait_dav("rst_dav_rise");
    repeat (5) tick();
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_dav", 32'(dacdav), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd1);
    check("midrst_cmd", 32'(daccmd), 32'd0);
    check("midrst_pulses", 32'({ack0, ack1, err0, err1}), 32'd0);
    req0 = 1'b0; req1 = 1'b1; cmd1 = 8'h42; davdac = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    check("midrst_gnt1", 32'(gnt), 32'd1);
    check("midrst_cmd1", 32'(daccmd), 32'h42);
    n = 0;
    while (!ack1 && n < 20) begin
      tick();
      n++;
    end
    check("midrst_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0; davdac = 1'b0;
    repeat (3) tick();

    // RELEASE hold while davdac stays high
    do_reset();
    req0 = 1'b1;
    wait_dav("rel_dav_rise");
    davdac = 1'b1;
    tick();
    check("rel_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0; req1 = 1'b1;
    saw_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy || dacdav) saw_bad = 1'b1;
    end
    check("rel_hold", 32'(saw_bad), 32'd0);
    davdac = 1'b0;
    tick();
    check("rel_idle", 32'(busy), 32'd0);
    repeat (2) tick();
    check("rel_next_dav", 32'(dacdav), 32'd1);
    check("rel_next_gnt", 32'(gnt), 32'd1);
    davdac = 1'b1;
    tick();
    req1 = 1'b0; davdac = 1'b0;
    repeat (3) tick();

    // Randomized traffic, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
      if (ack0 || err0)                  req0 = 1'b0;
      else if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if (ack1 || err1)                  req1 = 1'b0;
      else if ($urandom_range(0, 7) == 0) req1 = ~req1;
      cmd0  = 8'($urandom); data0 = 8'($urandom);
      cmd1  = 8'($urandom); data1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) davdac = ~davdac;
      tick();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
